// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - load/store stage: data-cache request/response, load alignment, registered writeback
// Optional: define MEM_MISALIGN_TRAP_EN to trap size-misaligned accesses without a cache request.
module mem_stage #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_mem_addr,
  input  logic [4:0]        in_dest,
  input  logic              in_store,
  input  logic              in_load,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [31:0]       in_pc,
  input  logic              flush,
  output logic              stall_out,
  output logic              dc_req_valid,
  input  logic              dc_req_ready,
  output logic [ADDR_W-1:0] dc_req_addr,
  output logic              dc_req_we,
  output logic [DATA_W-1:0] dc_req_wdata,
  output logic [7:0]        dc_req_strb,
  input  logic              dc_resp_valid,
  input  logic [DATA_W-1:0] dc_resp_data,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [4:0]        wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       wb_pc,
  output logic              bus_err
`ifdef MEM_MISALIGN_TRAP_EN
 ,output logic              misalign
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_is_load;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [4:0]        r_dest;
  logic [31:0]       r_pc;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_sdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_wb_valid;
  logic              r_wb_en;
  logic [4:0]        r_wb_dest;
  logic [DATA_W-1:0] r_wb_data;
  logic [31:0]       r_wb_pc;
  logic              r_bus_err;

  logic              w_in_mem;
  logic              w_accept_alu;
  logic              w_accept_mem;
  logic              w_cnt_last;
  logic              w_timeout;
  logic              w_resp_ok;
  logic              w_in_req;
  logic [ADDR_W-1:0] w_in_addr;
  logic [2:0]        w_lane;
  logic [5:0]        w_shamt;
  logic [7:0]        w_size_mask;
  logic [DATA_W-1:0] w_rshift;
  logic [DATA_W-1:0] w_ldata;

  assign w_in_mem     = in_load | in_store;
  assign w_in_addr    = in_load ? in_data[ADDR_W-1:0] : in_mem_addr;
  assign w_accept_alu = (r_state == S_IDLE) & in_valid & ~flush & ~w_in_mem;
  assign w_accept_mem = (r_state == S_IDLE) & in_valid & ~flush & w_in_mem;
  assign w_cnt_last   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_resp_ok    = (r_state == S_WAIT) & dc_resp_valid;
  assign w_in_req     = (r_state == S_REQ);
  assign w_lane       = r_addr[2:0];
  assign w_shamt      = {w_lane, 3'b000};
  assign w_rshift     = dc_resp_data >> w_shamt;

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_in_mis;
  logic r_misalign;

  always_comb begin
    w_in_mis = 1'b0;
    case (in_size)
      2'd1:    w_in_mis = w_in_addr[0];
      2'd2:    w_in_mis = |w_in_addr[1:0];
      2'd3:    w_in_mis = |w_in_addr[2:0];
      default: w_in_mis = 1'b0;
    endcase
  end

  assign misalign = r_misalign;
`endif

  always_comb begin
    w_size_mask = 8'hFF;
    w_ldata     = w_rshift;
    case (r_size)
      2'd0: begin
        w_size_mask = 8'h01;
        w_ldata     = {{56{~r_uns & w_rshift[7]}}, w_rshift[7:0]};
      end
      2'd1: begin
        w_size_mask = 8'h03;
        w_ldata     = {{48{~r_uns & w_rshift[15]}}, w_rshift[15:0]};
      end
      2'd2: begin
        w_size_mask = 8'h0F;
        w_ldata     = {{32{~r_uns & w_rshift[31]}}, w_rshift[31:0]};
      end
      default: begin
        w_size_mask = 8'hFF;
        w_ldata     = w_rshift;
      end
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept_mem) begin
          w_next = S_REQ;
`ifdef MEM_MISALIGN_TRAP_EN
          if (w_in_mis) w_next = S_WB;
`endif
        end
      end
      S_REQ: begin
        if (dc_req_ready) begin
          w_next = r_is_load ? S_WAIT : S_WB;
        end else if (w_cnt_last) begin
          w_next    = S_WB;
          w_timeout = 1'b1;
        end
      end
      S_WAIT: begin
        // A response arriving on the timeout cycle still wins.
        if (dc_resp_valid) begin
          w_next = S_WB;
        end else if (w_cnt_last) begin
          w_next    = S_WB;
          w_timeout = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (r_state == S_REQ || r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
      else r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_load <= 1'b0;
      r_size    <= 2'd0;
      r_uns     <= 1'b0;
      r_dest    <= 5'd0;
      r_pc      <= 32'd0;
      r_addr    <= '0;
      r_sdata   <= '0;
    end else if (w_accept_mem) begin
      r_is_load <= in_load;
      r_size    <= in_size;
      r_uns     <= in_unsigned;
      r_dest    <= in_dest;
      r_pc      <= in_pc;
      r_addr    <= w_in_addr;
      r_sdata   <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_valid <= 1'b0;
      r_wb_en    <= 1'b0;
      r_wb_dest  <= 5'd0;
      r_wb_data  <= '0;
      r_wb_pc    <= 32'd0;
      r_bus_err  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_en    <= 1'b0;
      r_bus_err  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
      if (w_accept_alu) begin
        r_wb_valid <= 1'b1;
        r_wb_en    <= (in_dest != 5'd0);
        r_wb_data  <= in_data;
        r_wb_dest  <= in_dest;
        r_wb_pc    <= in_pc;
      end else if ((r_state == S_REQ || r_state == S_WAIT) && w_next == S_WB) begin
        r_wb_valid <= 1'b1;
        r_wb_en    <= w_resp_ok & (r_dest != 5'd0);
        r_wb_data  <= w_resp_ok ? w_ldata : '0;
        r_wb_dest  <= r_dest;
        r_wb_pc    <= r_pc;
        r_bus_err  <= w_timeout;
      end
`ifdef MEM_MISALIGN_TRAP_EN
      else if (w_accept_mem && w_in_mis) begin
        r_wb_valid <= 1'b1;
        r_wb_data  <= '0;
        r_wb_dest  <= in_dest;
        r_wb_pc    <= in_pc;
        r_misalign <= 1'b1;
      end
`endif
    end
  end

  assign stall_out    = reset & ((r_state != S_IDLE) | w_accept_mem);
  assign dc_req_valid = w_in_req;
  assign dc_req_addr  = w_in_req ? {r_addr[ADDR_W-1:3], 3'b000} : '0;
  assign dc_req_we    = w_in_req & ~r_is_load;
  assign dc_req_wdata = (w_in_req & ~r_is_load) ? (r_sdata << w_shamt) : '0;
  assign dc_req_strb  = w_in_req ? (w_size_mask << w_lane) : 8'd0;
  assign wb_valid     = r_wb_valid;
  assign wb_en        = r_wb_en;
  assign wb_dest      = r_wb_dest;
  assign wb_data      = r_wb_data;
  assign wb_pc        = r_wb_pc;
  assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized bench for mem_stage against a byte-addressed memory model
// Optional: define MEM_MISALIGN_TRAP_EN to also exercise the misalignment trap.
module tb_mem_stage;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_store, in_load, in_unsigned, flush;
  logic [63:0] in_data, in_mem_addr;
  logic [4:0]  in_dest;
  logic [1:0]  in_size;
  logic [31:0] in_pc;
  logic        stall_out, dc_req_valid, dc_req_ready, dc_req_we, dc_resp_valid;
  logic [63:0] dc_req_addr, dc_req_wdata, dc_resp_data, wb_data;
  logic [7:0]  dc_req_strb;
  logic        wb_valid, wb_en, bus_err;
  logic [4:0]  wb_dest;
  logic [31:0] wb_pc;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [logic [63:0]];

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_mem_addr  (in_mem_addr),
    .in_dest      (in_dest),
    .in_store     (in_store),
    .in_load      (in_load),
    .in_size      (in_size),
    .in_unsigned  (in_unsigned),
    .in_pc        (in_pc),
    .flush        (flush),
    .stall_out    (stall_out),
    .dc_req_valid (dc_req_valid),
    .dc_req_ready (dc_req_ready),
    .dc_req_addr  (dc_req_addr),
    .dc_req_we    (dc_req_we),
    .dc_req_wdata (dc_req_wdata),
    .dc_req_strb  (dc_req_strb),
    .dc_resp_valid(dc_resp_valid),
    .dc_resp_data (dc_resp_data),
    .wb_valid     (wb_valid),
    .wb_en        (wb_en),
    .wb_dest      (wb_dest),
    .wb_data      (wb_data),
    .wb_pc        (wb_pc),
    .bus_err      (bus_err)
`ifdef MEM_MISALIGN_TRAP_EN
   ,.misalign     (misalign)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [63:0] rd_dword(input logic [63:0] a);
    logic [63:0] base;
    logic [63:0] v;
    base = {a[63:3], 3'b000};
    for (int i = 0; i < 8; i++) v[8*i +: 8] = rd_byte(base + 64'(i));
    return v;
  endfunction

  // Little-endian read of 2^sz bytes, then sign/zero extension.
  function automatic logic [63:0] exp_load(input logic [63:0] a, input logic [1:0] sz, input bit uns);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd_byte(a + 64'(i));
    if (!uns && n < 8 && v[8*n-1])
      for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_store = 0; in_load = 0; in_unsigned = 0; flush = 0;
    in_data = '0; in_mem_addr = '0; in_dest = '0; in_size = '0; in_pc = '0;
  endtask

  task automatic alu_op(input logic [63:0] d, input logic [4:0] dest);
    logic [31:0] pc;
    pc = $urandom;
    in_valid = 1; in_load = 0; in_store = 0; in_data = d; in_dest = dest; in_pc = pc;
    #1 check("alu_stall", stall_out, 0);
    tick();
    in_valid = 0;
    check("alu_wb_valid", wb_valid, 1);
    check("alu_wb_en", wb_en, dest != 5'd0);
    check("alu_wb_data", wb_data, d);
    check("alu_wb_dest", wb_dest, dest);
    check("alu_wb_pc", wb_pc, pc);
    check("alu_no_req", dc_req_valid, 0);
    tick();
    check("alu_wb_clear", wb_valid, 0);
  endtask

  task automatic mem_op(input bit ld, input logic [1:0] sz, input bit uns, input logic [63:0] addr,
                        input logic [63:0] sdata, input logic [4:0] dest,
                        input int rdly, input int pdly, input bit noresp);
    int n, cyc, req_cyc, resp_cyc, n_err;
    bit seen, accepted, drv_ready, resp_sent, stable, done, to_req, exp_to;
    logic [31:0]  pc;
    logic [7:0]   exp_strb, s0;
    logic [63:0]  exp_wb, a0, d0;
    logic         w0;
    n = 1 << sz;
    cyc = 0; req_cyc = 0; resp_cyc = 0; n_err = 0;
    seen = 0; accepted = 0; drv_ready = 0; resp_sent = 0; stable = 1; done = 0;
    a0 = '0; d0 = '0; s0 = '0; w0 = 0;
    to_req = (rdly >= TO);
    exp_to = to_req || (ld && noresp);
    exp_strb = '0;
    for (int i = 0; i < n; i++) exp_strb[(int'(addr[2:0]) + i) % 8] = 1'b1;
    exp_wb = ld ? exp_load(addr, sz, uns) : '0;
    pc = $urandom;
    in_valid = 1; in_load = ld; in_store = !ld; in_size = sz; in_unsigned = uns;
    in_dest = dest; in_pc = pc;
    in_data = ld ? addr : sdata;
    in_mem_addr = ld ? {$urandom, $urandom} : addr;
    #1 check("mem_stall_accept", stall_out, 1);
    while (!done && cyc < 2000) begin
      tick();
      cyc++;
      in_valid = 0;
      if (bus_err) n_err++;
      if (drv_ready) begin
        accepted = 1; drv_ready = 0; dc_req_ready = 0;
        if (!ld) for (int i = 0; i < n; i++) mem[addr + 64'(i)] = sdata[8*i +: 8];
      end
      if (dc_resp_valid) begin
        dc_resp_valid = 0; dc_resp_data = '0;
      end
      if (wb_valid) begin
        done = 1;
        check("wb_en", wb_en, ld && !exp_to && dest != 5'd0);
        if (ld && !exp_to) check("wb_data", wb_data, exp_wb);
        check("wb_dest", wb_dest, dest);
        check("wb_pc", wb_pc, pc);
        check("wb_stall", stall_out, 1);
        check("wb_bus_err", bus_err, exp_to);
        check("req_stable", stable, 1);
        if (to_req) check("to_cycles_req", req_cyc, TO);
        else if (exp_to) check("to_cycles_wait", resp_cyc, TO);
        else check("accepted", accepted, 1);
      end else begin
        if (dc_req_valid && !accepted) begin
          if (!seen) begin
            seen = 1;
            a0 = dc_req_addr; s0 = dc_req_strb; d0 = dc_req_wdata; w0 = dc_req_we;
            check("req_addr", dc_req_addr, {addr[63:3], 3'b000});
            check("req_strb", dc_req_strb, exp_strb);
            check("req_we", dc_req_we, !ld);
            if (!ld) check("req_wdata", dc_req_wdata, sdata << (8 * addr[2:0]));
          end else if (a0 !== dc_req_addr || s0 !== dc_req_strb || d0 !== dc_req_wdata || w0 !== dc_req_we) begin
            stable = 0;
          end
          req_cyc++;
          if (req_cyc > rdly) begin
            dc_req_ready = 1; drv_ready = 1;
          end
        end
        if (accepted && ld) begin
          resp_cyc++;
          if (!noresp && !resp_sent && resp_cyc > pdly) begin
            dc_resp_valid = 1; dc_resp_data = rd_dword(addr); resp_sent = 1;
          end
        end
      end
    end
    if (!done) check("wb_budget", 0, 1);
    dc_req_ready = 0; dc_resp_valid = 0;
    tick();
    n_err += int'(bus_err);
    check("idle_after_wb", {stall_out, wb_valid, dc_req_valid, bus_err}, 4'b0000);
    check("bus_err_count", n_err, exp_to);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [63:0] a, sd;
    int          kind;
    idle_inputs();
    reset = 0; dc_req_ready = 0; dc_resp_valid = 0; dc_resp_data = '0;
    tick();
    check("rst_outputs", {stall_out, dc_req_valid, dc_req_we, dc_req_strb, wb_valid, wb_en, bus_err}, '0);
    check("rst_wb_data", wb_data, 0);
    @(negedge clk) reset = 1;
    tick();

    dc_resp_valid = 1; dc_resp_data = 64'h1;
    tick();
    dc_resp_valid = 0;
    tick();
    check("stray_resp_idle", {wb_valid, stall_out}, 2'b00);

    alu_op(64'h1234, 5'd5);
    alu_op(64'h1234, 5'd0);

    for (int i = 0; i < 8; i++) mem[64'h1000 + 64'(i)] = 8'h00;
    mem[64'h1003] = 8'h80;
    mem_op(1, 2'd0, 0, 64'h1003, 0, 5'd7, 0, 1, 0);
    mem_op(1, 2'd0, 1, 64'h1003, 0, 5'd7, 1, 0, 0);
    mem_op(0, 2'd2, 0, 64'h2004, 64'hDEADBEEF, 5'd3, 3, 0, 0);
    mem_op(1, 2'd2, 0, 64'h2004, 0, 5'd9, 0, 2, 0);
    mem_op(1, 2'd3, 0, 64'h2000, 0, 5'd0, 0, 0, 0);

    // Response never arrives, then a late one must be ignored.
    mem_op(1, 2'd3, 0, 64'h5000, 0, 5'd4, 0, 0, 1);
    dc_resp_valid = 1; dc_resp_data = 64'hFFFF;
    tick();
    dc_resp_valid = 0;
    check("late_resp_ignored", {wb_valid, stall_out}, 2'b00);
    tick();
    check("late_resp_ignored2", wb_valid, 0);
    mem_op(0, 2'd1, 0, 64'h5008, 64'h7777, 5'd4, TO + 10, 0, 0);

    in_valid = 1; in_load = 1; in_size = 2'd3; in_data = 64'h6000; in_dest = 5'd2; flush = 1;
    tick();
    idle_inputs();
    check("flush_no_req", {dc_req_valid, wb_valid}, 2'b00);
    tick();
    check("flush_no_req2", {dc_req_valid, wb_valid, stall_out}, 3'b000);

    in_valid = 1; in_load = 1; in_size = 2'd3; in_data = 64'h6000; in_dest = 5'd2;
    tick();
    idle_inputs();
    check("rstw_req", dc_req_valid, 1);
    dc_req_ready = 1;
    tick();
    dc_req_ready = 0;
    check("rstw_wait", {dc_req_valid, stall_out}, 2'b01);
    #3 reset = 0;
    #1;
    check("rstw_outputs", {stall_out, dc_req_valid, dc_req_we, dc_req_strb, wb_valid, wb_en, bus_err, wb_dest}, '0);
    check("rstw_wb_data", wb_data, 0);
    check("rstw_wb_pc", wb_pc, 0);
    @(negedge clk) reset = 1;
    tick();

`ifdef MEM_MISALIGN_TRAP_EN
    in_valid = 1; in_load = 1; in_size = 2'd1; in_data = 64'h3001; in_dest = 5'd6;
    #1 check("mis_stall", stall_out, 1);
    tick();
    idle_inputs();
    check("mis_wb", {wb_valid, wb_en, misalign, dc_req_valid}, 4'b1010);
    tick();
    check("mis_clear", {wb_valid, misalign, dc_req_valid, stall_out}, 4'b0000);
`endif

    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3));
      a = 64'h4000 + (64'($urandom_range(0, 63)) & ~((64'd1 << sz) - 64'd1));
      sd = {$urandom, $urandom};
      if (kind == 0) alu_op(sd, 5'($urandom));
      else mem_op(kind == 1, sz, 1'($urandom), a, sd, 5'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
